// File: rtl/mpi_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : mpi_bus_master
// Description : Command-driven MPI-bus master. Executes word read, word write
//               and byte write cycles on the active-low multiplexed nAD bus
//               with configurable address/data timing, a synchronised nRPLY
//               and a per-edge bus timeout that aborts a hung cycle.
//
// Ports:
//   CLKp, RSTp           bus clock, synchronous active-high reset
//   req_valid/req_ready  command handshake (ready only while idle)
//   req_write, req_byte  cycle type (byte qualifies writes only)
//   req_addr, req_wdata  address and write data, true polarity
//   rsp_valid            one-clock completion pulse
//   rsp_rdata, rsp_err   read data (true polarity) and timeout flag
//   ad_o/ad_oe/ad_i      nAD pad drive value, enable and input
//   nSYNC_o/nSYNC_oe     nSYNC pad drive value and enable
//   nWTBT_o/nDIN_o/nDOUT_o, ctrl_oe   control strobes and their shared enable
//   nBSY_o               open-drain nBSY (0 = pull low, 1 = release)
//   nRPLY_i              raw nRPLY from the pad
//
// Revision    : 1.0 - initial release
// ============================================================================
module mpi_bus_master #(
    parameter int AW      = 16,
    parameter int T_ASET  = 2,
    parameter int T_AHLD  = 1,
    parameter int T_DSET  = 2,
    parameter int TIMEOUT = 64,
    parameter int SYNC_N  = 2
) (
    input  logic          CLKp,
    input  logic          RSTp,
    // request / response port
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic          req_byte,
    input  logic [AW-1:0] req_addr,
    input  logic [15:0]   req_wdata,
    output logic          rsp_valid,
    output logic [15:0]   rsp_rdata,
    output logic          rsp_err,
    // MPI pad side
    output logic [15:0]   ad_o,
    output logic          ad_oe,
    input  logic [15:0]   ad_i,
    output logic          nSYNC_o,
    output logic          nSYNC_oe,
    output logic          nWTBT_o,
    output logic          nDIN_o,
    output logic          nDOUT_o,
    output logic          ctrl_oe,
    output logic          nBSY_o,
    input  logic          nRPLY_i
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int CW = $clog2(TIMEOUT + 1);

    // Phase counters compare against "last clock of phase" values so that a
    // phase of N clocks runs with the counter at 0 .. N-1.
    localparam logic [CW-1:0] c_aset_last = CW'(T_ASET - 1);
    localparam logic [CW-1:0] c_ahld_last = CW'(T_AHLD - 1);
    localparam logic [CW-1:0] c_dset_last = CW'(T_DSET - 1);
    localparam logic [CW-1:0] c_tmo_last  = CW'(TIMEOUT - 1);

    localparam logic [3:0] c_st_idle   = 4'd0;
    localparam logic [3:0] c_st_addr   = 4'd1;
    localparam logic [3:0] c_st_sync   = 4'd2;
    localparam logic [3:0] c_st_data   = 4'd3;
    localparam logic [3:0] c_st_strobe = 4'd4;
    localparam logic [3:0] c_st_rel    = 4'd5;
    localparam logic [3:0] c_st_end    = 4'd6;
    localparam logic [3:0] c_st_float  = 4'd7;
    localparam logic [3:0] c_st_abort  = 4'd8;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [CW-1:0]     r_cnt;
    logic [SYNC_N-1:0] r_rply_sync;
    logic              w_rply;
    logic              w_accept;
    logic              w_capture;
    logic              w_tmo;
    logic [15:0]       w_addr16;
    logic [15:0]       w_wdata_bus;

    logic              r_write;
    logic              r_byte;
    logic [15:0]       r_addr;
    logic [15:0]       r_wdata;
    logic [15:0]       r_rdata;
    logic              r_err;

    // ------------------------------------------------------------------
    // Address width adaptation: only 16 address bits exist on the bus.
    // ------------------------------------------------------------------
    generate
        if (AW >= 16) begin : g_addr_wide
            assign w_addr16 = req_addr[15:0];
        end else begin : g_addr_narrow
            assign w_addr16 = {{(16 - AW){1'b0}}, req_addr};
        end
    endgenerate

    // ------------------------------------------------------------------
    // nRPLY synchroniser. Resets to the released (high) level so a reset
    // never looks like a pending reply.
    // ------------------------------------------------------------------
    generate
        if (SYNC_N > 1) begin : g_rply_sync
            always_ff @(posedge CLKp) begin
                if (RSTp) begin
                    r_rply_sync <= '1;
                end else begin
                    r_rply_sync <= {r_rply_sync[SYNC_N-2:0], nRPLY_i};
                end
            end
        end else begin : g_rply_sync_min
            always_ff @(posedge CLKp) begin
                if (RSTp) begin
                    r_rply_sync <= '1;
                end else begin
                    r_rply_sync <= nRPLY_i;
                end
            end
        end
    endgenerate

    assign w_rply   = ~r_rply_sync[SYNC_N-1];
    assign w_accept = req_valid && (r_state == c_st_idle);

    // Byte writes place the low byte on both lanes of the bus.
    assign w_wdata_bus = r_byte ? ~{r_wdata[7:0], r_wdata[7:0]} : ~r_wdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLKp) begin
        if (RSTp) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_tmo     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (req_valid) begin
                    w_next = c_st_addr;
                end
            end
            c_st_addr: begin
                if (r_cnt == c_aset_last) begin
                    w_next = c_st_sync;
                end
            end
            c_st_sync: begin
                if (r_cnt == c_ahld_last) begin
                    w_next = c_st_data;
                end
            end
            c_st_data: begin
                if (r_cnt == c_dset_last) begin
                    w_next = c_st_strobe;
                end
            end
            c_st_strobe: begin
                // A reply already present on entry is accepted as-is; a
                // stuck-low line is then caught by the release timeout.
                if (w_rply) begin
                    w_next    = c_st_rel;
                    w_capture = ~r_write;
                end else if (r_cnt == c_tmo_last) begin
                    w_next = c_st_abort;
                    w_tmo  = 1'b1;
                end
            end
            c_st_rel: begin
                if (!w_rply) begin
                    w_next = c_st_end;
                end else if (r_cnt == c_tmo_last) begin
                    w_next = c_st_abort;
                    w_tmo  = 1'b1;
                end
            end
            c_st_abort: w_next = c_st_end;
            c_st_end:   w_next = c_st_float;
            c_st_float: w_next = c_st_idle;
            default:    w_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Phase/timeout counter and command/response registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLKp) begin
        if (RSTp) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_byte  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            // Counter restarts on every state change and rests at 0 when idle.
            if ((w_next != r_state) || (r_state == c_st_idle)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_accept) begin
                r_write <= req_write;
                r_byte  <= req_byte & req_write;
                r_addr  <= w_addr16;
                r_wdata <= req_wdata;
                // Cleared per command so writes and aborted reads return 0.
                r_rdata <= '0;
                r_err   <= 1'b0;
            end

            if (w_capture) begin
                r_rdata <= ~ad_i;
            end

            if (w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // ------------------------------------------------------------------
    // Output decode (Moore)
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ad_o      = 16'hFFFF;
        ad_oe     = 1'b0;
        nSYNC_o   = 1'b1;
        nSYNC_oe  = 1'b0;
        nWTBT_o   = 1'b1;
        nDIN_o    = 1'b1;
        nDOUT_o   = 1'b1;
        ctrl_oe   = 1'b0;
        nBSY_o    = 1'b1;
        case (r_state)
            c_st_idle: begin
                req_ready = 1'b1;
            end
            c_st_addr: begin
                nBSY_o  = 1'b0;
                ctrl_oe = 1'b1;
                ad_oe   = 1'b1;
                ad_o    = ~r_addr;
                nWTBT_o = ~r_write;
            end
            c_st_sync: begin
                nBSY_o   = 1'b0;
                ctrl_oe  = 1'b1;
                ad_oe    = 1'b1;
                ad_o     = ~r_addr;
                nWTBT_o  = ~r_write;
                nSYNC_oe = 1'b1;
                nSYNC_o  = 1'b0;
            end
            c_st_data: begin
                nBSY_o   = 1'b0;
                ctrl_oe  = 1'b1;
                nSYNC_oe = 1'b1;
                nSYNC_o  = 1'b0;
                // Reads turn the bus around here so the slave can drive it.
                ad_oe    = r_write;
                ad_o     = r_write ? w_wdata_bus : 16'hFFFF;
            end
            c_st_strobe: begin
                nBSY_o   = 1'b0;
                ctrl_oe  = 1'b1;
                nSYNC_oe = 1'b1;
                nSYNC_o  = 1'b0;
                ad_oe    = r_write;
                ad_o     = r_write ? w_wdata_bus : 16'hFFFF;
                nDIN_o   = r_write;
                nDOUT_o  = ~r_write;
                nWTBT_o  = r_write ? ~r_byte : 1'b1;
            end
            c_st_rel: begin
                nBSY_o   = 1'b0;
                ctrl_oe  = 1'b1;
                nSYNC_oe = 1'b1;
                nSYNC_o  = 1'b0;
            end
            c_st_abort: begin
                // Strobes and data released; bus ownership held until END.
                nBSY_o   = 1'b0;
                nSYNC_oe = 1'b1;
                nSYNC_o  = 1'b0;
            end
            c_st_end: begin
                // Drive nSYNC high for one clock before floating it.
                nSYNC_oe = 1'b1;
                nSYNC_o  = 1'b1;
            end
            c_st_float: begin
                rsp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
